// File: rtl/cal_fifo_reader_pkg.sv
// Shared types and constants for the calibration FIFO reader.
//   state_t     : reader FSM states (IDLE, STREAM, DRAIN)
//   PAYLOAD_MSB : top bit of the payload byte inside a FIFO word
//   EOP_BIT     : end-of-packet marker bit inside a FIFO word
package cal_fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int unsigned PAYLOAD_MSB = 7;
   localparam int unsigned EOP_BIT     = 8;

endpackage

// File: rtl/cal_skid_fifo.sv
// Small synchronous FIFO that absorbs words already requested from the upstream FIFO.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   push, push_data : write one word
//   pop             : remove the head word (ignored while empty)
//   head            : current head word
//   count           : number of words held
// DEPTH must be a power of two so the pointers wrap naturally.
module cal_skid_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;

   assign do_pop = pop && (count_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         // Push and pop in one cycle net to no change.
         count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset: nothing reads it while count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/cal_fifo_reader.sv
// Reads packets from an upstream synchronous FIFO and presents them as an AXI-Stream.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   enable              : level, permits reading from the FIFO
//   fifo_empty, fifo_q  : upstream FIFO status and read data (valid RD_LAT cycles after fifo_re)
//   fifo_re             : upstream FIFO read enable
//   m_tvalid, m_tready, m_tdata, m_tlast : stream output
//   pkt_cnt             : completed packet count (wraps)
//   busy                : FSM not idle
//   err_len             : sticky overlong-packet flag
// Build option: define CAL_FIFO_READER_LENCHK_EN to compile in the MAX_PKT length check;
// without it err_len is tied low.
module cal_fifo_reader
   import cal_fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_W    = 9,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned MAX_PKT   = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_re,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [7:0]        m_tdata,
   output logic              m_tlast,
   output logic [15:0]       pkt_cnt,
   output logic              busy,
   output logic              err_len
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned IF_W  = $clog2(RD_LAT + 1);
   localparam int unsigned OCC_W = $clog2(BUF_DEPTH + RD_LAT + 1);

   state_t            state_q, state_d;
   logic [RD_LAT-1:0] re_pipe_q, re_pipe_d;
   logic [IF_W-1:0]   inflight;
   logic [OCC_W-1:0]  occ;
   logic [CNT_W-1:0]  buf_count;
   logic [CNT_W-1:0]  eop_cnt_q, eop_cnt_d;
   logic [DATA_W-1:0] head;
   logic              capture;
   logic              buf_empty;
   logic              pop;
   logic              tlast_out;
   logic              in_pkt_q;
   logic              read_ok;
   logic [15:0]       pkt_cnt_q;

   // ---------------------------------------------------------------- read pipeline
   always_comb begin
      re_pipe_d    = '0;
      re_pipe_d[0] = fifo_re;
      for (int i = 1; i < RD_LAT; i++) begin
         re_pipe_d[i] = re_pipe_q[i-1];
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + IF_W'(re_pipe_q[i]);
      end
   end

   assign capture   = re_pipe_q[RD_LAT-1];
   assign occ       = OCC_W'(inflight) + OCC_W'(buf_count);
   assign read_ok   = !fifo_empty && (occ < OCC_W'(BUF_DEPTH));
   assign buf_empty = (buf_count == '0);

   cal_skid_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_data (fifo_q),
      .pop       (pop),
      .head      (head),
      .count     (buf_count)
   );

   // ---------------------------------------------------------------- stream output
   assign m_tvalid = !buf_empty;
   assign pop      = m_tvalid && m_tready;
   assign m_tdata  = m_tvalid ? head[PAYLOAD_MSB:0] : 8'h00;
   assign m_tlast  = m_tvalid && tlast_out;

`ifdef CAL_FIFO_READER_LENCHK_EN
   localparam int unsigned LEN_W = $clog2(MAX_PKT + 1);

   logic [LEN_W-1:0] len_q;
   logic             err_q;
   logic             force_last;

   // len_q counts words of the current packet already popped; the head is word len_q+1.
   assign force_last = (len_q == LEN_W'(MAX_PKT - 1)) && !head[EOP_BIT];
   assign tlast_out  = head[EOP_BIT] || force_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= '0;
         err_q <= 1'b0;
      end else if (pop) begin
         len_q <= tlast_out ? '0 : len_q + LEN_W'(1);
         if (force_last) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_len = err_q;
`else
   assign tlast_out = head[EOP_BIT];
   assign err_len   = 1'b0;
`endif

   // TLAST words sitting in the skid buffer; DRAIN stops requesting once one is present.
   assign eop_cnt_d = eop_cnt_q + CNT_W'(capture && fifo_q[EOP_BIT])
                                - CNT_W'(pop && head[EOP_BIT]);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      fifo_re = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            fifo_re = enable && read_ok;
            if (!enable) begin
               if (in_pkt_q) begin
                  state_d = DRAIN;
               end else if (buf_empty && inflight == '0) begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            // One word at a time, so nothing past the packet's TLAST is ever requested.
            fifo_re = read_ok && in_pkt_q && eop_cnt_q == '0 && inflight == '0;
            if (!in_pkt_q && buf_empty && inflight == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         re_pipe_q <= '0;
         eop_cnt_q <= '0;
         in_pkt_q  <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         re_pipe_q <= re_pipe_d;
         eop_cnt_q <= eop_cnt_d;
         if (pop) begin
            in_pkt_q <= !tlast_out;
            if (tlast_out) begin
               pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
         end
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign busy    = (state_q != IDLE);

endmodule
